systolic_drain: RTL and testbench
=================================

# systolic_drain

Result-drain for the N×N systolic multiplier array. It snapshots every PE's accumulator (`o_y`) in a single cycle when the array signals completion, then streams the N·N results out in row-major order over a valid/ready interface. This lets the array clear its accumulators and start the next product while results are still being read. It sits between the PE grid outputs and the downstream result consumer.

## Interface
Parameters:
- `N`, default 4: array dimension (N ≥ 2).
- `OUTWIDTH`, default 8: width of one PE accumulator.
- `IDXW`, default `$clog2(N)`: width of the row/column index outputs.

Ports (clock and reset first):
- `i_clk`, input, 1: single clock. All logic is on its rising edge.
- `i_arst`, input, 1: asynchronous, active-high reset.
- `i_capture`, input, 1: pulse asserted in a cycle where all `i_y` values are final. This is the last cycle with `i_doProcess` high at the PEs.
- `i_y`, input, N·N·OUTWIDTH: flattened PE outputs. Element (r,c) is `i_y[(r*N+c)*OUTWIDTH +: OUTWIDTH]`.
- `o_valid`, output, 1: `o_data` holds a valid result.
- `i_ready`, input, 1: consumer accepts `o_data`.
- `o_data`, output, OUTWIDTH: current result element.
- `o_row`, output, IDXW: row index of `o_data`.
- `o_col`, output, IDXW: column index of `o_data`.
- `o_last`, output, 1: current element is (N-1,N-1).
- `o_busy`, output, 1: a snapshot is held or being streamed.
- `o_overrun`, output, 1: sticky flag; a capture arrived while busy.
- `i_clearErr`, input, 1: clears `o_overrun`.

## Operation
- State machine, two states:
  - IDLE: buffer empty.
  - STREAM: buffer holds a snapshot; elements are being presented.
- IDLE → STREAM on `i_capture`:
  - all N·N words of `i_y` are latched into the snapshot buffer;
  - the index counter is set to 0.
- In STREAM:
  - `o_valid` = 1.
  - `o_data` = buffer[idx].
  - `o_row` = idx / N; `o_col` = idx mod N.
  - `o_last` = (idx == N·N−1).
- Handshake rules:
  - A transfer occurs in any cycle where `o_valid && i_ready`.
  - On a transfer, idx increments.
  - While `o_valid && !i_ready`, `o_data`, `o_row`, `o_col` and `o_last` hold stable.
- On the transfer of the last element:
  - with `i_capture` low in that cycle → next state IDLE;
  - with `i_capture` high in that cycle → stay in STREAM, re-snapshot, idx = 0. This gives back-to-back frames without a bubble and raises no overrun.
- `i_capture` in STREAM, other than in the last-transfer cycle:
  - the capture is ignored;
  - the buffer and idx are unaffected;
  - `o_overrun` is set.
- `o_overrun` behaviour:
  - cleared by `i_clearErr`;
  - if set and clear occur in the same cycle, set wins.
- `o_busy` = (state == STREAM).
- Data is passed unsigned and unmodified; no arithmetic on the payload.
- idx width is `$clog2(N*N)`. idx never exceeds N·N−1; there is no wrap inside a frame.

## Timing
- Reset values (asynchronous): state IDLE, idx 0, `o_valid` 0, `o_data` 0, `o_row` 0, `o_col` 0, `o_last` 0, `o_busy` 0, `o_overrun` 0. Buffer contents are cleared to 0.
- Capture latency: `i_capture` sampled at edge k → `o_valid` = 1 with element (0,0) after edge k (visible in cycle k+1).
- Throughput: one element per cycle with `i_ready` held high. A full frame takes N·N cycles. Back-to-back frames take N·N cycles each.
- `o_valid` deasserts the cycle after the final transfer, unless a same-cycle capture occurred.
- All outputs are registered, or decoded directly from registered state/idx plus the buffer mux. There is no combinational path from `i_ready` or `i_capture` to any output.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is discarded.

## Structure
- Shared package `systolic_pkg`:
  - state enum `drain_state_t` {IDLE, STREAM};
  - helper function `rc_of(idx)` returning the row/column pair.
  - Defaults for `N` and `OUTWIDTH` are shared with the PE grid top.
- Snapshot buffer: flat register array, loaded in parallel and read through an N·N:1 mux.
- One natural sub-module, `rc_counter`:
  - holds the linear idx plus separate row/col counters, so no divider is needed;
  - col wraps N−1 → 0 and increments row.

## Test plan
N=4, OUTWIDTH=8 unless noted.
1. Reset, then capture with `i_y` element (r,c) = 16r+c, `i_ready`=1 → 16 consecutive transfers 0x00,0x01,…,0x33 with correct row/col. `o_last` is high only on 0x33. `o_busy` falls one cycle later.
2. Same frame with `i_ready` toggling 1,0,0,1,… → no element skipped or duplicated; outputs stable during every stall.
3. Capture asserted in the cycle of the 16th transfer with new data 0xA0+idx → element 0xA0 presented the next cycle. No idle cycle, `o_overrun`=0.
4. Capture at transfer 5 of a frame → stream continues with the original data; `o_overrun`=1 and stays set. `i_clearErr` clears it. Set and clear in the same cycle leave it 1.
5. Assert `i_arst` at transfer 7 → all outputs 0 immediately. A subsequent capture restarts from (0,0).
6. N=2, OUTWIDTH=16, values 0xFFFF,0x0001,0x8000,0x1234 → exact 16-bit values streamed in order, with `o_row`/`o_col` using IDXW=1.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic multiplier array and its result drain.
package systolic_pkg;

  localparam int N_DEFAULT        = 4;
  localparam int OUTWIDTH_DEFAULT = 8;

  typedef enum logic {
    IDLE,
    STREAM
  } drain_state_t;

  typedef struct packed {
    logic [15:0] row;
    logic [15:0] col;
  } rc_t;

  // Row/column of a linear row-major index in an n-wide grid.
  function automatic rc_t rc_of(input int unsigned idx, input int unsigned n);
    rc_t rc;
    rc.row = 16'(idx / n);
    rc.col = 16'(idx % n);
    return rc;
  endfunction

endpackage

// File: rtl/systolic_drain_rc_counter.sv
// Linear element index with parallel row/column counters, so the drain never divides.
module rc_counter #(
  parameter int N    = 4,
  parameter int IDXW = $clog2(N),
  parameter int CW   = $clog2(N * N)
) (
  input  logic            i_clk,
  input  logic            i_arst,
  input  logic            i_clear,
  input  logic            i_inc,
  output logic [CW-1:0]   o_idx,
  output logic [IDXW-1:0] o_row,
  output logic [IDXW-1:0] o_col,
  output logic            o_last
);

  localparam logic [CW-1:0]   LAST_IDX = CW'(N * N - 1);
  localparam logic [IDXW-1:0] COL_MAX  = IDXW'(N - 1);

  logic [CW-1:0]   idx_reg;
  logic [IDXW-1:0] row_reg;
  logic [IDXW-1:0] col_reg;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      idx_reg <= '0;
      row_reg <= '0;
      col_reg <= '0;
    end else if (i_clear) begin
      idx_reg <= '0;
      row_reg <= '0;
      col_reg <= '0;
    end else if (i_inc) begin
      idx_reg <= idx_reg + 1'b1;
      if (col_reg == COL_MAX) begin
        col_reg <= '0;
        row_reg <= row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  assign o_idx  = idx_reg;
  assign o_row  = row_reg;
  assign o_col  = col_reg;
  assign o_last = (idx_reg == LAST_IDX);

endmodule

// File: rtl/systolic_drain.sv
// Snapshots all PE accumulators in one cycle and streams them row-major over valid/ready,
// freeing the array to start the next product while results drain.
module systolic_drain
  import systolic_pkg::*;
#(
  parameter int N        = N_DEFAULT,
  parameter int OUTWIDTH = OUTWIDTH_DEFAULT,
  parameter int IDXW     = $clog2(N)
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_capture,
  input  logic [N*N*OUTWIDTH-1:0] i_y,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [OUTWIDTH-1:0]   o_data,
  output logic [IDXW-1:0]       o_row,
  output logic [IDXW-1:0]       o_col,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_overrun,
  input  logic                  i_clearErr
);

  localparam int NN = N * N;
  localparam int CW = $clog2(NN);

  drain_state_t state_reg, state_next;
  logic         overrun_reg;
  logic         busy;
  logic         xfer;
  logic         last_xfer;
  logic         load;
  logic         overrun_set;
  logic [CW-1:0]   idx;
  logic [IDXW-1:0] row;
  logic [IDXW-1:0] col;
  logic            cnt_last;
  logic [OUTWIDTH-1:0] buf_reg [NN];

  assign busy        = (state_reg == STREAM);
  assign xfer        = busy && i_ready;
  assign last_xfer   = xfer && cnt_last;
  assign overrun_set = i_capture && busy && !last_xfer;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_reg   <= IDLE;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      overrun_reg <= overrun_set | (overrun_reg & ~i_clearErr);
    end
  end

  // A capture landing on the final transfer reloads without leaving STREAM.
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (i_capture) begin
          state_next = STREAM;
          load       = 1'b1;
        end
      end
      STREAM: begin
        if (last_xfer) begin
          if (i_capture) load = 1'b1;
          else           state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < NN; gi++) begin : g_buf
      always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst)    buf_reg[gi] <= '0;
        else if (load) buf_reg[gi] <= i_y[gi*OUTWIDTH +: OUTWIDTH];
      end
    end
  endgenerate

  rc_counter #(
    .N    (N),
    .IDXW (IDXW),
    .CW   (CW)
  ) u_rc_counter (
    .i_clk   (i_clk),
    .i_arst  (i_arst),
    .i_clear (load | last_xfer),
    .i_inc   (xfer & ~cnt_last),
    .o_idx   (idx),
    .o_row   (row),
    .o_col   (col),
    .o_last  (cnt_last)
  );

  assign o_valid   = busy;
  assign o_busy    = busy;
  assign o_overrun = overrun_reg;
  assign o_data    = busy ? buf_reg[idx] : '0;
  assign o_row     = row;
  assign o_col     = col;
  assign o_last    = busy & cnt_last;

endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain: fixed vector table, corner-case sequences and random traffic
// checked against a queue-of-elements reference model.
module tb_systolic_drain;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int NN = N * N;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  logic            cap = 1'b0, rdy = 1'b0, clr = 1'b0;
  logic [NN*W-1:0] y = '0;
  logic            valid, last, busy, ov;
  logic [W-1:0]    data;
  logic [1:0]      row, col;

  logic        cap2 = 1'b0, rdy2 = 1'b0, clr2 = 1'b0;
  logic [63:0] y2 = '0;
  logic        valid2, last2, busy2, ov2;
  logic [15:0] data2;
  logic [0:0]  row2, col2;

  systolic_drain #(.N(N), .OUTWIDTH(W)) dut (
    .i_clk(clk), .i_arst(arst), .i_capture(cap), .i_y(y),
    .o_valid(valid), .i_ready(rdy), .o_data(data), .o_row(row), .o_col(col),
    .o_last(last), .o_busy(busy), .o_overrun(ov), .i_clearErr(clr)
  );

  systolic_drain #(.N(2), .OUTWIDTH(16)) dut2 (
    .i_clk(clk), .i_arst(arst), .i_capture(cap2), .i_y(y2),
    .o_valid(valid2), .i_ready(rdy2), .o_data(data2), .o_row(row2), .o_col(col2),
    .o_last(last2), .o_busy(busy2), .o_overrun(ov2), .i_clearErr(clr2)
  );

  typedef struct {
    logic [W-1:0] data;
    int           row;
    int           col;
    bit           last;
  } elem_t;

  typedef struct {
    bit           cap;
    bit           rdy;
    bit           exp_valid;
    logic [W-1:0] exp_data;
    int           exp_row;
    int           exp_col;
    bit           exp_last;
    bit           exp_busy;
  } vec_t;

  elem_t q[$];
  bit    m_ov = 1'b0;
  int    vectors = 0;
  int    miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a frame is a queue of elements; a capture is taken only when the queue is empty
  // after this cycle's transfer, otherwise it flags an overrun.
  task automatic model_edge();
    bit xfer, lastx, set;
    xfer  = (q.size() > 0) && rdy;
    lastx = xfer && q[0].last;
    set   = cap && (q.size() > 0) && !lastx;
    if (xfer) begin
      $display("xfer data=%02h row=%0d col=%0d last=%0d", q[0].data, q[0].row, q[0].col, q[0].last);
      void'(q.pop_front());
    end
    if (cap && q.size() == 0) begin
      for (int i = 0; i < NN; i++) begin
        elem_t e;
        e.data = y[i*W +: W];
        e.row  = i / N;
        e.col  = i % N;
        e.last = (i == NN - 1);
        q.push_back(e);
      end
    end
    m_ov = set | (m_ov & !clr);
  endtask

  task automatic check_model();
    chk("valid", 32'(valid), 32'(q.size() > 0));
    chk("busy", 32'(busy), 32'(q.size() > 0));
    chk("overrun", 32'(ov), 32'(m_ov));
    if (q.size() > 0) begin
      chk("data", 32'(data), 32'(q[0].data));
      chk("row", 32'(row), 32'(q[0].row));
      chk("col", 32'(col), 32'(q[0].col));
      chk("last", 32'(last), 32'(q[0].last));
    end
  endtask

  task automatic step(input bit c, input bit r, input bit cl);
    cap = c;
    rdy = r;
    clr = cl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic load_y(input logic [7:0] base, input bit grid);
    for (int i = 0; i < NN; i++)
      y[i*W +: W] = grid ? 8'(16 * (i / N) + (i % N)) : 8'(base + 8'(i));
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (q.size() > 0 && k < 200) begin
      step(1'b0, 1'b1, 1'b0);
      k++;
    end
    if (k >= 200) chk({tag, "_drain_timeout"}, 32'(q.size()), 32'd0);
  endtask

  vec_t tbl[18];
  bit   rpat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    // Table for a full 16r+c frame with ready held high.
    tbl[0] = '{1'b1, 1'b1, 1'b1, 8'h00, 0, 0, 1'b0, 1'b1};
    for (int k = 1; k < NN; k++)
      tbl[k] = '{1'b0, 1'b1, 1'b1, 8'(16 * (k / N) + (k % N)), k / N, k % N, (k == NN - 1), 1'b1};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 0, 1'b0, 1'b0};

    @(negedge clk);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_row", 32'(row), 0);
    chk("rst_col", 32'(col), 0);
    chk("rst_last", 32'(last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(ov), 0);
    chk("rst2_valid", 32'(valid2), 0);
    chk("rst2_data", 32'(data2), 0);
    @(negedge clk);
    arst = 1'b0;

    // 1: table-driven frame
    load_y(8'h00, 1'b1);
    for (int k = 0; k < 18; k++) begin
      step(tbl[k].cap, tbl[k].rdy, 1'b0);
      chk($sformatf("t1_valid[%0d]", k), 32'(valid), 32'(tbl[k].exp_valid));
      chk($sformatf("t1_busy[%0d]", k), 32'(busy), 32'(tbl[k].exp_busy));
      chk($sformatf("t1_last[%0d]", k), 32'(last), 32'(tbl[k].exp_last));
      if (tbl[k].exp_valid) begin
        chk($sformatf("t1_data[%0d]", k), 32'(data), 32'(tbl[k].exp_data));
        chk($sformatf("t1_row[%0d]", k), 32'(row), 32'(tbl[k].exp_row));
        chk($sformatf("t1_col[%0d]", k), 32'(col), 32'(tbl[k].exp_col));
      end
    end

    // 2: ready toggling 1,0,0,1,...
    step(1'b1, 1'b0, 1'b0);
    begin
      int k = 0;
      while (q.size() > 0 && k < 100) begin
        step(1'b0, rpat[k % 4], 1'b0);
        k++;
      end
      if (k >= 100) chk("t2_timeout", 32'(q.size()), 0);
    end

    // 3: capture on the 16th transfer gives a bubble-free second frame
    step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < NN - 1; k++) step(1'b0, 1'b1, 1'b0);
    load_y(8'hA0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("t3_valid", 32'(valid), 1);
    chk("t3_data", 32'(data), 32'h A0);
    chk("t3_overrun", 32'(ov), 0);
    drain("t3");
    step(1'b0, 1'b1, 1'b0);

    // 4: overrun mid-frame, then clear, then set+clear together
    load_y(8'h40, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0);
    load_y(8'hC0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("t4_overrun_set", 32'(ov), 1);
    chk("t4_orig_data", 32'(data), 32'h45);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0);
    chk("t4_overrun_sticky", 32'(ov), 1);
    step(1'b0, 1'b1, 1'b1);
    chk("t4_overrun_clear", 32'(ov), 0);
    step(1'b1, 1'b1, 1'b1);
    chk("t4_set_wins", 32'(ov), 1);
    step(1'b0, 1'b1, 1'b1);
    drain("t4");

    // 5: reset mid-frame
    load_y(8'h00, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 1'b0);
    arst = 1'b1;
    #1;
    chk("t5_valid", 32'(valid), 0);
    chk("t5_data", 32'(data), 0);
    chk("t5_row", 32'(row), 0);
    chk("t5_col", 32'(col), 0);
    chk("t5_busy", 32'(busy), 0);
    q.delete();
    m_ov = 1'b0;
    @(negedge clk);
    arst = 1'b0;
    load_y(8'h70, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("t5_restart_data", 32'(data), 32'h70);
    chk("t5_restart_row", 32'(row), 0);
    chk("t5_restart_col", 32'(col), 0);
    drain("t5");

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NN * W / 32; i++) y[i*32 +: 32] = $urandom;
      step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end
    drain("rand");
    cap = 1'b0;
    clr = 1'b0;

    // 6: N=2, 16-bit words
    begin
      logic [15:0] v2[4] = '{16'hFFFF, 16'h0001, 16'h8000, 16'h1234};
      for (int i = 0; i < 4; i++) y2[i*16 +: 16] = v2[i];
      cap2 = 1'b1;
      rdy2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cap2 = 1'b0;
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t6_valid[%0d]", i), 32'(valid2), 1);
        chk($sformatf("t6_data[%0d]", i), 32'(data2), 32'(v2[i]));
        chk($sformatf("t6_row[%0d]", i), 32'(row2), 32'(i / 2));
        chk($sformatf("t6_col[%0d]", i), 32'(col2), 32'(i % 2));
        chk($sformatf("t6_last[%0d]", i), 32'(last2), 32'(i == 3));
        $display("xfer2 data=%04h row=%0d col=%0d", data2, row2, col2);
        @(posedge clk);
        @(negedge clk);
      end
      chk("t6_valid_end", 32'(valid2), 0);
      chk("t6_busy_end", 32'(busy2), 0);
      chk("t6_overrun", 32'(ov2), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
